// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN_DEF = 32;
    localparam int PC_STEP  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; clear wins over push/pop, pointers wrap modulo DEPTH.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     wdata,
    input  logic                       pop,
    input  logic                       clear,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    // Qualify requests: a push into a full FIFO is accepted only alongside a pop.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (clear) begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
        end else begin
            do_pop_s  = pop && (count_r != CNT_W'(0));
            do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= entry_t'(0);
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (clear) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: one outstanding imem request, prefetch FIFO, stall and redirect handling.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_killed / perf_stall counters.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_killed,
    output logic [31:0]     perf_stall,
`endif
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    fetch_state_e    state_r;
    fetch_state_e    state_next_s;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] target_pc_s;
    logic            run_r;
    logic            push_s;
    logic            pop_s;
    logic            room_s;
    logic            issue_s;
    logic            full_s;
    logic            empty_s;
    logic [CNT_W-1:0] count_s;
    logic            unused_s;
    entry_t          push_entry_s;
    entry_t          head_s;

    // run_r keeps imem_req low while reset is asserted and for the first cycle after release.
    assign target_pc_s  = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
    assign pop_s        = !empty_s && !stall && !redirect;
    assign push_s       = (state_r == BUSY) && imem_ack && !redirect;
    assign room_s       = !full_s || pop_s;
    assign issue_s      = run_r && (state_r == IDLE) && room_s && !redirect;
    assign push_entry_s = '{pc: fetch_pc_r, instr: imem_rdata};
    assign unused_s     = ^count_s;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (push_entry_s),
        .pop   (pop_s),
        .clear (redirect),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; an ack seen in IDLE is a protocol error and is ignored.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_s) state_next_s = BUSY;
                else         state_next_s = IDLE;
            end
            BUSY: begin
                if (imem_ack)      state_next_s = IDLE;
                else if (redirect) state_next_s = KILL;
                else               state_next_s = BUSY;
            end
            KILL: begin
                if (imem_ack) state_next_s = IDLE;
                else          state_next_s = KILL;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs and decode-facing view of the FIFO head.
    always_comb begin
        imem_req  = issue_s;
        imem_addr = fetch_pc_r;
        if (empty_s) begin
            if_valid = 1'b0;
            if_instr = {XLEN{1'b0}};
            if_pc    = {XLEN{1'b0}};
        end else begin
            if_valid = 1'b1;
            if_instr = head_s.instr;
            if_pc    = head_s.pc;
        end
    end

    // Fetch PC: redirect target (word aligned) wins over sequential advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            run_r      <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (redirect) begin
                fetch_pc_r <= target_pc_s;
            end else if (push_s) begin
                fetch_pc_r <= fetch_pc_r + XLEN'(PC_STEP);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic kill_s;
    assign kill_s = imem_ack && ((state_r == KILL) || ((state_r == BUSY) && redirect));

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= 32'd0;
            perf_killed  <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            perf_fetched <= perf_fetched + {31'd0, push_s};
            perf_killed  <= perf_killed + {31'd0, kill_s};
            perf_stall   <= perf_stall + {31'd0, (!empty_s && stall)};
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a transaction-level FIFO/memory model.
module tb_fetch_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
    logic [31:0] perf_stall;
`endif

    fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_killed (perf_killed),
        .perf_stall  (perf_stall),
`endif
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_next = 32'h0;
    logic [31:0] m_addr = 32'h0;
    bit          m_out = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_rstale = 1'b0;
    int          m_due = 0;
    int          lat = 1;
    int          cyc = 0;
    int          m_fetched = 0;
    int          m_killed = 0;
    int          m_stalled = 0;
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    int          pop_cyc[$];
    int          first_valid = -1;
    bit          last_ack = 1'b0;
    bit          last_req = 1'b0;
    bit          saw_dead = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_next = RESET_PC;
        if (m_out) m_rstale = 1'b1;
        m_fetched = 0;
        m_killed = 0;
        m_stalled = 0;
        req_log.delete();
        req_cyc.delete();
        pop_pc.delete();
        pop_instr.delete();
        pop_cyc.delete();
        first_valid = -1;
    endtask

    // One clock cycle: memory responds, outputs are checked against the model, model advances.
    task automatic cycle();
        bit          ack_now;
        bit          exp_valid;
        bit          pop;
        logic [31:0] dat;
        ack_now    = m_out && (cyc == m_due);
        dat        = (m_stale || m_rstale) ? 32'hDEAD_BEEF : instr_of(m_addr);
        imem_ack   = ack_now;
        imem_rdata = ack_now ? dat : (32'h5A5A_0000 ^ 32'(cyc));
        #1;
        last_ack  = ack_now;
        last_req  = imem_req;
        exp_valid = (q.size() != 0);
        pop       = exp_valid && !stall && !redirect;
        if (rst) begin
            chk("if_valid", 32'(if_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("if_pc", if_pc, q[0].pc);
                chk("if_instr", if_instr, q[0].instr);
            end else begin
                chk("if_pc_empty", if_pc, 32'h0);
                chk("if_instr_empty", if_instr, 32'h0);
            end
            if (if_instr == 32'hDEAD_BEEF) saw_dead = 1'b1;
            if (if_valid && first_valid < 0) first_valid = cyc;
            if (imem_req) begin
                chk("req_addr", imem_addr, m_next);
                chk("req_overlap", 32'(m_out && !ack_now), 32'h0);
                chk("req_no_room", 32'((q.size() - int'(pop)) >= DEPTH), 32'h0);
                chk("req_in_redirect", 32'(redirect), 32'h0);
            end
            if (exp_valid && stall) m_stalled++;
            if (pop) begin
                pop_pc.push_back(if_pc);
                pop_instr.push_back(if_instr);
                pop_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (ack_now) begin
                if (!m_stale && !m_rstale && !redirect) begin
                    q.push_back('{pc: m_addr, instr: dat});
                    m_next = m_addr + 32'd4;
                    m_fetched++;
                end else if (!m_rstale) begin
                    m_killed++;
                end
                m_out = 1'b0;
            end
            if (redirect) begin
                q.delete();
                m_next = redirect_pc & 32'hFFFF_FFFC;
                if (m_out) m_stale = 1'b1;
            end
            if (imem_req) begin
                req_log.push_back(imem_addr);
                req_cyc.push_back(cyc);
                m_out    = 1'b1;
                m_addr   = imem_addr;
                m_due    = cyc + lat;
                m_stale  = 1'b0;
                m_rstale = 1'b0;
            end
        end else if (ack_now) begin
            m_out = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_req(input int bound);
        int n;
        n = 0;
        last_req = 1'b0;
        while (!last_req && n < bound) begin
            cycle();
            n++;
        end
        chk("wait_req_timeout", 32'(last_req), 32'h1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        model_reset();
        cycle();
        cycle();
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int idx_r;
        int idx_p;
        @(negedge clk);

        // Sequential fetch with a 1-cycle memory.
        do_reset();
        lat = 1;
        repeat (14) cycle();
        chk("t1_addr0", req_log[0], 32'h0);
        chk("t1_addr1", req_log[1], 32'h4);
        chk("t1_addr2", req_log[2], 32'h8);
        chk("t1_gap1", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
        chk("t1_gap2", 32'(req_cyc[2] - req_cyc[1]), 32'd2);
        chk("t1_latency", 32'(first_valid - req_cyc[0]), 32'd2);
        chk("t1_pc0", pop_pc[0], 32'h0);
        chk("t1_pc1", pop_pc[1], 32'h4);
        chk("t1_pc2", pop_pc[2], 32'h8);
        chk("t1_instr0", pop_instr[0], 32'hA000_0000);
        chk("t1_instr1", pop_instr[1], 32'hA000_0004);
        chk("t1_instr2", pop_instr[2], 32'hA000_0008);

        // Stall fills the FIFO, then it drains back to back.
        do_reset();
        stall = 1'b1;
        repeat (10) cycle();
        chk("t2_nreq", 32'(req_log.size()), 32'd4);
        chk("t2_req_when_full", 32'(last_req), 32'h0);
        stall = 1'b0;
        repeat (6) cycle();
        chk("t2_pop0", pop_pc[0], 32'h0);
        chk("t2_pop1", pop_pc[1], 32'h4);
        chk("t2_pop2", pop_pc[2], 32'h8);
        chk("t2_pop3", pop_pc[3], 32'hC);
        chk("t2_consec", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);

        // Redirect while BUSY; stale response arrives later.
        do_reset();
        lat = 1;
        repeat (6) cycle();
        lat = 3;
        wait_req(10);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        idx_r = req_log.size();
        idx_p = pop_pc.size();
        saw_dead = 1'b0;
        cycle();
        redirect = 1'b0;
        lat = 1;
        repeat (12) cycle();
        chk("t3_addr", req_log[idx_r], 32'h100);
        chk("t3_first_pc", pop_pc[idx_p], 32'h100);
        chk("t3_no_dead", 32'(saw_dead), 32'h0);

        // Redirect coinciding with the ack; unaligned target.
        lat = 2;
        stall = 1'b1;
        wait_req(10);
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'h203;
        cycle();
        redirect = 1'b0;
        chk("t4_ack_in_redirect", 32'(last_ack), 32'h1);
        #1;
        chk("t4_valid", 32'(if_valid), 32'h0);
        chk("t4_req", 32'(imem_req), 32'h1);
        chk("t4_addr", imem_addr, 32'h200);
        stall = 1'b0;
        lat = 1;
        repeat (8) cycle();

        // Asynchronous reset mid-BUSY with two entries buffered.
        do_reset();
        stall = 1'b1;
        lat = 1;
        n = 0;
        while (q.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("t5_fill", 32'(q.size()), 32'd2);
        lat = 3;
        wait_req(10);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_req", 32'(imem_req), 32'h0);
        chk("t5_async_addr", imem_addr, RESET_PC);
        chk("t5_async_valid", 32'(if_valid), 32'h0);
        chk("t5_async_instr", if_instr, 32'h0);
        chk("t5_async_pc", if_pc, 32'h0);
        model_reset();
        cycle();
        cycle();
        rst = 1'b1;
        lat = 1;
        repeat (8) cycle();
        chk("t5_first_addr", req_log[0], RESET_PC);
        #1;
        chk("t5_head_pc", if_pc, 32'h0);
        chk("t5_head_instr", if_instr, 32'hA000_0000);

`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'(m_fetched));
        chk("perf_killed", perf_killed, 32'(m_killed));
        chk("perf_stall", perf_stall, 32'(m_stalled));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
